bar_collision_checker: RTL

- Consumer end of the environment bar interface.
- Runs the horizontal scroll of the bird through bar columns 1..6 and checks bird_y against the current bar's opening. Keeps score and level.
- Drives `pause` and `level` back into the environment block.
- Sits between the bird physics block and the environment block, on the game tick clock.

---
 rtl/bar_collision_checker.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bar_collision_checker.sv
// ---------------------------------------------------------------------------
// bar_collision_checker
//   Consumer end of the environment bar interface. It scrolls the bird through
//   bar columns FIRST_BAR..LAST_BAR, one game tick at a time. While the bird is
//   inside a bar column it checks bird_y against that bar's opening, and on
//   every tick it checks the bird against the ground line. It also keeps the
//   score and level, and drives pause/level back to the environment block.
//
//   Optional build macro: INVINCIBLE_EN
//     When defined, a hit pulses collide and increments hit_cnt (once per
//     column) but the game stays in PLAY. A bar with a hit scores nothing.
//
//   Ports
//     clkenv      game tick clock
//     rst         synchronous, active-high reset
//     start       start/restart request (level-sensitive, ignored in PLAY)
//     bird_y      top of bird, pixels
//     bar_posN    top of opening of bar N
//     bar_opN     opening height of bar N
//     pause       freezes the environment; high whenever not in PLAY
//     level       current level (saturates at 1023)
//     score       bars cleared this game (saturates at 1023)
//     cur_bar     bar index being approached/crossed
//     collide     one-tick pulse on a hit
//     game_over   high in HIT
//     hit_cnt     (INVINCIBLE_EN only) saturating hit counter
// ---------------------------------------------------------------------------
module bar_collision_checker #(
    parameter int unsigned BAR_W     = 4,
    parameter int unsigned COL_W     = 16,
    parameter int unsigned BIRD_H    = 20,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned FIRST_BAR = 1,
    parameter int unsigned LAST_BAR  = 6
) (
    input  logic        clkenv,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  bird_y,
    input  logic [9:0]  bar_pos1,
    input  logic [9:0]  bar_pos2,
    input  logic [9:0]  bar_pos3,
    input  logic [9:0]  bar_pos4,
    input  logic [9:0]  bar_pos5,
    input  logic [9:0]  bar_pos6,
    input  logic [9:0]  bar_pos7,
    input  logic [9:0]  bar_pos8,
    input  logic [9:0]  bar_op1,
    input  logic [9:0]  bar_op2,
    input  logic [9:0]  bar_op3,
    input  logic [9:0]  bar_op4,
    input  logic [9:0]  bar_op5,
    input  logic [9:0]  bar_op6,
    input  logic [9:0]  bar_op7,
    input  logic [9:0]  bar_op8,
    output logic        pause,
    output logic [9:0]  level,
    output logic [9:0]  score,
    output logic [2:0]  cur_bar,
`ifdef INVINCIBLE_EN
    output logic [9:0]  hit_cnt,
`endif
    output logic        collide,
    output logic        game_over
);

    localparam int unsigned X_W     = (COL_W > 1) ? $clog2(COL_W) : 1;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned ARITH_W = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic [X_W-1:0]      x_cnt_q,     x_cnt_d;
    logic [2:0]          cur_bar_q,   cur_bar_d;
    logic [CNT_W-1:0]    level_q,     level_d;
    logic [CNT_W-1:0]    score_q,     score_d;
    logic                collide_q,   collide_d;
    logic                pause_q,     pause_d;
    logic                game_over_q, game_over_d;
`ifdef INVINCIBLE_EN
    logic [CNT_W-1:0]    hit_cnt_q,   hit_cnt_d;
    logic                hit_seen_q,  hit_seen_d;
`endif

    logic [9:0]          sel_pos;
    logic [9:0]          sel_op;
    logic [ARITH_W-1:0]  bird_bot;
    logic [ARITH_W-1:0]  bar_bot;
    logic                in_window;
    logic                bar_hit;
    logic                ground_hit;
    logic                hit;
    logic                col_end;
    logic                score_tick;
    logic [X_W-1:0]      x_adv;
    logic [2:0]          cur_adv;
    logic [CNT_W-1:0]    level_adv;
    logic [CNT_W-1:0]    score_inc;

    // Bar mux. cur_bar values 0 and 7 are never reached; they are mapped
    // only so the mux is total.
    always_comb begin
        sel_pos = bar_pos1;
        sel_op  = bar_op1;
        case (cur_bar_q)
            3'd1:    begin sel_pos = bar_pos1; sel_op = bar_op1; end
            3'd2:    begin sel_pos = bar_pos2; sel_op = bar_op2; end
            3'd3:    begin sel_pos = bar_pos3; sel_op = bar_op3; end
            3'd4:    begin sel_pos = bar_pos4; sel_op = bar_op4; end
            3'd5:    begin sel_pos = bar_pos5; sel_op = bar_op5; end
            3'd6:    begin sel_pos = bar_pos6; sel_op = bar_op6; end
            3'd7:    begin sel_pos = bar_pos7; sel_op = bar_op7; end
            default: begin sel_pos = bar_pos8; sel_op = bar_op8; end
        endcase
    end

    // Collision checks in 11 bits so that the sums cannot wrap. Touching an
    // opening edge or the ground line exactly is not a hit.
    always_comb begin
        bird_bot   = ARITH_W'(bird_y) + ARITH_W'(BIRD_H);
        bar_bot    = ARITH_W'(sel_pos) + ARITH_W'(sel_op);
        in_window  = (x_cnt_q < X_W'(BAR_W));
        bar_hit    = in_window &&
                     ((ARITH_W'(bird_y) < ARITH_W'(sel_pos)) || (bird_bot > bar_bot));
        ground_hit = (bird_bot > ARITH_W'(SCREEN_H));
        hit        = bar_hit || ground_hit;
        col_end    = (x_cnt_q == X_W'(COL_W - 1));
        score_tick = (x_cnt_q == X_W'(BAR_W - 1));
    end

    // Scroll progression for a tick in which the game keeps running.
    always_comb begin
        x_adv     = col_end ? '0 : x_cnt_q + X_W'(1);
        cur_adv   = cur_bar_q;
        level_adv = level_q;
        if (col_end) begin
            if (cur_bar_q == 3'(LAST_BAR)) begin
                cur_adv = 3'(FIRST_BAR);
                if (level_q != CNT_MAX) begin
                    level_adv = level_q + CNT_W'(1);
                end
            end else begin
                cur_adv = cur_bar_q + 3'd1;
            end
        end
        score_inc = (score_q != CNT_MAX) ? score_q + CNT_W'(1) : score_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        cur_bar_d = cur_bar_q;
        level_d   = level_q;
        score_d   = score_q;
        collide_d = 1'b0;
`ifdef INVINCIBLE_EN
        hit_cnt_d  = hit_cnt_q;
        hit_seen_d = hit_seen_q;
`endif
        case (state_q)
            ST_IDLE, ST_HIT: begin
                if (start) begin
                    state_d   = ST_PLAY;
                    x_cnt_d   = '0;
                    cur_bar_d = 3'(FIRST_BAR);
                    level_d   = CNT_W'(1);
                    score_d   = '0;
`ifdef INVINCIBLE_EN
                    hit_cnt_d  = '0;
                    hit_seen_d = 1'b0;
`endif
                end
            end
            ST_PLAY: begin
`ifdef INVINCIBLE_EN
                // Only the first hit in a column is reported; the column
                // boundary rearms the detector.
                if (hit && !hit_seen_q) begin
                    collide_d = 1'b1;
                    if (hit_cnt_q != CNT_MAX) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                end
                x_cnt_d   = x_adv;
                cur_bar_d = cur_adv;
                level_d   = level_adv;
                if (score_tick && !hit && !hit_seen_q) begin
                    score_d = score_inc;
                end
                hit_seen_d = col_end ? 1'b0 : (hit_seen_q || hit);
`else
                // A hit freezes the game on the same edge: nothing else updates.
                if (hit) begin
                    state_d   = ST_HIT;
                    collide_d = 1'b1;
                end else begin
                    x_cnt_d   = x_adv;
                    cur_bar_d = cur_adv;
                    level_d   = level_adv;
                    if (score_tick) begin
                        score_d = score_inc;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        pause_d     = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_HIT);
    end

    // State and output registers.
    always_ff @(posedge clkenv) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_cnt_q     <= '0;
            cur_bar_q   <= 3'(FIRST_BAR);
            level_q     <= CNT_W'(1);
            score_q     <= '0;
            collide_q   <= 1'b0;
            pause_q     <= 1'b1;
            game_over_q <= 1'b0;
`ifdef INVINCIBLE_EN
            hit_cnt_q   <= '0;
            hit_seen_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            cur_bar_q   <= cur_bar_d;
            level_q     <= level_d;
            score_q     <= score_d;
            collide_q   <= collide_d;
            pause_q     <= pause_d;
            game_over_q <= game_over_d;
`ifdef INVINCIBLE_EN
            hit_cnt_q   <= hit_cnt_d;
            hit_seen_q  <= hit_seen_d;
`endif
        end
    end

    assign pause     = pause_q;
    assign level     = level_q;
    assign score     = score_q;
    assign cur_bar   = cur_bar_q;
    assign collide   = collide_q;
    assign game_over = game_over_q;
`ifdef INVINCIBLE_EN
    assign hit_cnt   = hit_cnt_q;
`endif

endmodule
